alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter W, default 8: operand and result width, legal range 4..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  3  operation code, sampled on accept.
REQ-007 a, b  input  W each  operands, sampled on accept.
REQ-008 out_valid  output  1  result and flags valid.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 result  output  W  operation result.
REQ-011 zero_f, over_f, cout_f, less_f  output  1 each  status flags.

Function
REQ-012 Op codes: 000 add, 001 sub, 010 signed less-than, 011 and, 100 or, 101 xor, 110 equal, 111 unsigned multiply (low W bits).
REQ-013 States: IDLE, MUL, DONE; in_ready = (state==IDLE) and rst_n high; accept = in_valid and in_ready.
REQ-014 IDLE + accept, op != 111: result and flags registered on the accept edge, go to DONE; out_valid high the next cycle (latency 1).
REQ-015 IDLE + accept, op == 111: latch a, b, clear accumulator, go to MUL; W shift-add iterations, one per cycle, via a cycle counter 0..W-1.
REQ-016 MUL: after the W-th iteration edge, go to DONE; out_valid high exactly W cycles after the accept edge.
REQ-017 DONE: out_valid=1; result/flags held stable until out_valid and out_ready on the same edge, then IDLE; in_ready high the following cycle (no same-cycle reissue).
REQ-018 Inputs a, b, op are ignored when not accepted; changes during MUL/DONE have no effect.
REQ-019 add/sub: {cout_f,result} = a + (b xor {W{sub}}) + sub; cout_f for sub = no-borrow; over_f = operand-sign match (after inversion) with result-sign mismatch.
REQ-020 less: internal subtract a-b; result = {W-1 zeros, less_f}; less_f = sum_msb xor over; cout_f/over_f from the subtract.
REQ-021 equal: result = {W-1 zeros, a==b}.
REQ-022 and/or/xor/equal: over_f=0, cout_f=0, less_f=0.
REQ-023 multiply: result = low W bits of a*b; cout_f = 1 iff high W bits nonzero; over_f=0, less_f=0.
REQ-024 zero_f = (result == 0) for every op.
REQ-025 less_f=0 for all ops except less.

Reset
REQ-026 rst_n low: state IDLE, counter 0, out_valid 0, result 0, all flags 0, in_ready 0, immediately and independent of clk.
REQ-027 Reset during MUL or DONE aborts the operation; no out_valid after release; in_ready 1 in the first cycle after release.

Structure
REQ-028 Package alu_pkg holds op-code constants, state enum, and W range limits.
REQ-029 One sub-module alu_comb (combinational add/sub/compare/logic, W-parametrised) instantiated once; multiply datapath and FSM live in alu_seq.

Verification (W=8)
REQ-030 add 7F+01 -> result 80, over_f=1, cout_f=0, zero_f=0, out_valid exactly 1 cycle after accept.
REQ-031 sub 05-05 -> result 00, zero_f=1, cout_f=1, over_f=0; less FF vs 01 -> result 01, less_f=1.
REQ-032 mul 15*17 -> result FF, cout_f=0, out_valid exactly 8 cycles after accept; mul 16*16 -> result 00, cout_f=1, zero_f=1.
REQ-033 out_ready held low 5 cycles in DONE -> result/flags stable, in_ready 0; out_ready high -> IDLE, in_ready 1 next cycle.
REQ-034 rst_n low at MUL cycle 3 -> out_valid 0 and outputs 0 immediately; no result after release; new add accepted first cycle after release.
REQ-035 Back-to-back stream (in_valid always high, out_ready always high) of xor, mul, and -> one result per request, in order, correct values, no accept while busy.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and width limits shared by the ALU files
package alu_pkg;

  localparam int W_MIN = 4;
  localparam int W_MAX = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SLT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_EQ  = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - single-cycle add/sub/compare/logic datapath
module alu_comb
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] result_o,
  output logic         over_o,
  output logic         cout_o,
  output logic         less_o
);

  logic         sub;
  logic [W-1:0] bx;
  logic [W:0]   sum;
  logic         ovf;

  always_comb begin
    // signed less-than reuses the subtractor
    sub      = (op_i == OP_SUB) || (op_i == OP_SLT);
    bx       = b_i ^ {W{sub}};
    sum      = {1'b0, a_i} + {1'b0, bx} + {{W{1'b0}}, sub};
    ovf      = (a_i[W-1] == bx[W-1]) && (sum[W-1] != a_i[W-1]);
    result_o = '0;
    over_o   = 1'b0;
    cout_o   = 1'b0;
    less_o   = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB: begin
        result_o = sum[W-1:0];
        over_o   = ovf;
        cout_o   = sum[W];
      end
      OP_SLT: begin
        less_o   = sum[W-1] ^ ovf;
        result_o = {{(W-1){1'b0}}, less_o};
        over_o   = ovf;
        cout_o   = sum[W];
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_EQ:   result_o = {{(W-1){1'b0}}, (a_i == b_i)};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with one-cycle ops and a W-cycle shift-add multiply
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero_f,
  output logic         over_f,
  output logic         cout_f,
  output logic         less_f
);

  localparam int CW = $clog2(W);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [2*W-1:0]   acc_q, acc_d, acc_step;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [W-1:0]     result_q, result_d;
  logic             zero_q, zero_d, over_q, over_d, cout_q, cout_d, less_q, less_d;
  logic [W-1:0]     c_result;
  logic             c_over, c_cout, c_less;
  logic             accept;

  alu_comb #(.W(W)) u_comb (
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .result_o (c_result),
    .over_o   (c_over),
    .cout_o   (c_cout),
    .less_o   (c_less)
  );

  assign in_ready  = (state_q == S_IDLE) && rst_n;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero_f    = zero_q;
  assign over_f    = over_q;
  assign cout_f    = cout_q;
  assign less_f    = less_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    over_d   = over_q;
    cout_d   = cout_q;
    less_d   = less_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mcand_d  = {{W{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d = c_result;
            zero_d   = (c_result == '0);
            over_d   = c_over;
            cout_d   = c_cout;
            less_d   = c_less;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        // one multiplier bit per cycle; the last step is registered straight into the result
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          result_d = acc_step[W-1:0];
          zero_d   = (acc_step[W-1:0] == '0);
          cout_d   = |acc_step[2*W-1:W];
          over_d   = 1'b0;
          less_d   = 1'b0;
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      over_q   <= 1'b0;
      cout_q   <= 1'b0;
      less_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      over_q   <= over_d;
      cout_q   <= cout_d;
      less_q   <= less_d;
    end
  end

endmodule
